branch_resolve_ctrl: RTL and testbench

//  Execute-stage sequencer for conditional branches and jumps. Accepts one control-flow op

---
 rtl/branch_resolve_ctrl.sv | 154 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch/jump resolver: evaluates the condition, checks the prediction, flushes and redirects fetch.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_unit (
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        taken
);
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) <  $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a <  b);
      3'b111:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end
endmodule

module branch_resolve_ctrl #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_funct3,
  input  logic              in_is_jal,
  input  logic              in_is_jalr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic              in_pred_taken,
  input  logic              kill,
  output logic              res_valid,
  output logic              res_taken,
  output logic [XLEN-1:0]   res_link,
  output logic              misalign_exc,
  output logic              flush,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [XLEN-1:0]   redir_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_REDIR} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        funct3_reg;
  logic              jal_reg, jalr_reg, pred_reg;
  logic [XLEN-1:0]   pc_reg, imm_reg, rs1_reg, rs2_reg, redir_pc_reg;

  logic              bu_taken, take, misalign, mispred, accept;
  logic [XLEN-1:0]   jalr_sum, target, link, next_pc;

  branch_unit u_bu (.funct3(funct3_reg), .a(rs1_reg), .b(rs2_reg), .taken(bu_taken));

  // Resolution datapath works purely on the latched op.
  always_comb begin
    jalr_sum = rs1_reg + imm_reg;
    target   = jalr_reg ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_reg + imm_reg);
    link     = pc_reg + XLEN'(4);
    take     = jal_reg | jalr_reg | bu_taken;
    next_pc  = take ? target : link;
    misalign = take & target[1];
    mispred  = ~misalign & ((take != pred_reg) | jalr_reg);
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (kill) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (accept) state_next = S_EVAL;
        S_EVAL:  state_next = mispred ? S_REDIR : S_IDLE;
        S_REDIR: if (redir_ready) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready     = (state_reg == S_IDLE) & ~kill & ~rst;
    res_valid    = (state_reg == S_EVAL) & ~kill;
    res_taken    = res_valid & take;
    res_link     = res_valid ? link : '0;
    misalign_exc = res_valid & misalign;
    flush        = res_valid & mispred;
    redir_valid  = (state_reg == S_REDIR) & ~kill;
    redir_pc     = redir_pc_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_reg   <= '0;
      jal_reg      <= 1'b0;
      jalr_reg     <= 1'b0;
      pred_reg     <= 1'b0;
      pc_reg       <= '0;
      imm_reg      <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      redir_pc_reg <= '0;
    end else begin
      if (accept) begin
        funct3_reg <= in_funct3;
        jal_reg    <= in_is_jal;
        jalr_reg   <= in_is_jalr;
        pred_reg   <= in_pred_taken;
        pc_reg     <= in_pc;
        imm_reg    <= in_imm;
        rs1_reg    <= in_rs1;
        rs2_reg    <= in_rs2;
      end
      if (flush) redir_pc_reg <= next_pc;
    end
  end

`ifdef BRANCH_STATS_EN
  // Index 0 counts resolved ops, index 1 counts entries into REDIRECT.
  logic [1:0]        stat_inc;
  logic [STAT_W-1:0] stat_cnt_reg [2];

  assign stat_inc = {flush, res_valid};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      always_ff @(posedge clk or posedge rst) begin
        if (rst)               stat_cnt_reg[gi] <= '0;
        else if (stat_inc[gi]) stat_cnt_reg[gi] <= stat_cnt_reg[gi] + STAT_W'(1);
      end
    end
  endgenerate

  assign stat_branches = stat_cnt_reg[0];
  assign stat_mispred  = stat_cnt_reg[1];
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed, table-driven bench for branch_resolve_ctrl plus hand-written kill/reset sequences.
module tb_branch_resolve_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_funct3;
  logic        in_is_jal, in_is_jalr;
  logic [31:0] in_pc, in_imm, in_rs1, in_rs2;
  logic        in_pred_taken, kill;
  logic        res_valid, res_taken;
  logic [31:0] res_link;
  logic        misalign_exc, flush, redir_valid, redir_ready;
  logic [31:0] redir_pc, stat_branches, stat_mispred;

  int checks = 0;
  int errors = 0;

  branch_resolve_ctrl #(.XLEN(32), .STAT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pred_taken(in_pred_taken), .kill(kill),
    .res_valid(res_valid), .res_taken(res_taken), .res_link(res_link),
    .misalign_exc(misalign_exc), .flush(flush),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        jal;
    logic        jalr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;
    logic        taken;
    logic [31:0] link;
    logic        mis;
    logic        fl;
    logic [31:0] rpc;
    int          hold;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_op(input vec_t v);
    in_valid      = 1'b1;
    in_funct3     = v.f3;
    in_is_jal     = v.jal;
    in_is_jalr    = v.jalr;
    in_pc         = v.pc;
    in_imm        = v.imm;
    in_rs1        = v.rs1;
    in_rs2        = v.rs2;
    in_pred_taken = v.pred;
  endtask

  task automatic run_op(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    drive_op(v);
    #1;
    chk({p, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({p, ".res_valid"}, 32'(res_valid), 32'd1);
    chk({p, ".res_taken"}, 32'(res_taken), 32'(v.taken));
    chk({p, ".res_link"}, res_link, v.link);
    chk({p, ".misalign"}, 32'(misalign_exc), 32'(v.mis));
    chk({p, ".flush"}, 32'(flush), 32'(v.fl));
    if (v.fl) begin
      @(negedge clk);
      for (int h = 0; h < v.hold; h++) begin
        #1;
        chk({p, ".hold_redir_valid"}, 32'(redir_valid), 32'd1);
        chk({p, ".hold_redir_pc"}, redir_pc, v.rpc);
        chk({p, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      redir_ready = 1'b1;
      #1;
      chk({p, ".redir_valid"}, 32'(redir_valid), 32'd1);
      chk({p, ".redir_pc"}, redir_pc, v.rpc);
      @(negedge clk);
      redir_ready = 1'b0;
    end else begin
      @(negedge clk);
    end
    #1;
    chk({p, ".post_redir_valid"}, 32'(redir_valid), 32'd0);
    chk({p, ".post_in_ready"}, 32'(in_ready), 32'd1);
    chk({p, ".post_res_valid"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    //           f3     jal  jalr pc            imm           rs1           rs2           pred taken link          mis  fl   rpc           hold
    vecs[0]  = '{3'b000, 1'b0, 1'b0, 32'h100,      32'h20,       32'd5,        32'd5,        1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0,   0};
    vecs[1]  = '{3'b100, 1'b0, 1'b0, 32'h100,      32'h20,       32'hFFFFFFFF, 32'd1,        1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 32'h120, 3};
    vecs[2]  = '{3'b110, 1'b0, 1'b0, 32'h100,      32'h20,       32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 32'h104, 1'b0, 1'b1, 32'h104, 0};
    vecs[3]  = '{3'b111, 1'b0, 1'b0, 32'h100,      32'h20,       32'd7,        32'd7,        1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0,   0};
    vecs[4]  = '{3'b010, 1'b0, 1'b0, 32'h100,      32'h20,       32'd0,        32'd0,        1'b0, 1'b0, 32'h104, 1'b0, 1'b0, 32'h0,   0};
    vecs[5]  = '{3'b000, 1'b0, 1'b1, 32'h100,      32'h0,        32'h2005,     32'd0,        1'b1, 1'b1, 32'h104, 1'b0, 1'b1, 32'h2004, 1};
    vecs[6]  = '{3'b000, 1'b0, 1'b1, 32'h100,      32'h0,        32'h2003,     32'd0,        1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h0,   0};
    vecs[7]  = '{3'b000, 1'b1, 1'b0, 32'h100,      32'h6,        32'd0,        32'd0,        1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h0,   0};
    vecs[8]  = '{3'b001, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h8,        32'd1,        32'd2,        1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h4,   0};
    vecs[9]  = '{3'b000, 1'b1, 1'b1, 32'h100,      32'h10,       32'h300,      32'd0,        1'b1, 1'b1, 32'h104, 1'b0, 1'b1, 32'h310, 0};
    vecs[10] = '{3'b101, 1'b0, 1'b0, 32'h100,      32'h20,       32'd1,        32'hFFFFFFFF, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 32'h120, 0};
    vecs[11] = '{3'b001, 1'b0, 1'b0, 32'h200,      32'h20,       32'd3,        32'd3,        1'b0, 1'b0, 32'h204, 1'b0, 1'b0, 32'h0,   0};
    vecs[12] = '{3'b000, 1'b1, 1'b0, 32'h100,      32'h40,       32'd0,        32'd0,        1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0,   0};
    vecs[13] = '{3'b000, 1'b0, 1'b0, 32'h100,      32'h22,       32'd9,        32'd9,        1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h0,   0};

    rst = 1'b1; kill = 1'b0; redir_ready = 1'b0; in_valid = 1'b0;
    in_funct3 = '0; in_is_jal = 1'b0; in_is_jalr = 1'b0;
    in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_pred_taken = 1'b0;

    @(negedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.res_valid", 32'(res_valid), 32'd0);
    chk("rst.flush", 32'(flush), 32'd0);
    chk("rst.redir_valid", 32'(redir_valid), 32'd0);
    chk("rst.redir_pc", redir_pc, 32'd0);
    chk("rst.stat_branches", stat_branches, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.in_ready_after", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) run_op(i, vecs[i]);

    // kill during EVAL: op vanishes, nothing reported, not counted
    @(negedge clk);
    drive_op(vecs[1]);
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b1;
    #1;
    chk("killA.res_valid", 32'(res_valid), 32'd0);
    chk("killA.flush", 32'(flush), 32'd0);
    chk("killA.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    kill = 1'b0;
    #1;
    chk("killA.idle_in_ready", 32'(in_ready), 32'd1);
    chk("killA.redir_valid", 32'(redir_valid), 32'd0);

    // kill during REDIRECT, colliding with redir_ready
    @(negedge clk);
    drive_op(vecs[1]);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("killB.flush", 32'(flush), 32'd1);
    @(negedge clk);
    kill = 1'b1; redir_ready = 1'b1;
    #1;
    chk("killB.redir_valid", 32'(redir_valid), 32'd0);
    chk("killB.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    kill = 1'b0; redir_ready = 1'b0;
    #1;
    chk("killB.idle_in_ready", 32'(in_ready), 32'd1);
    chk("killB.idle_redir_valid", 32'(redir_valid), 32'd0);

    // kill in IDLE blocks acceptance
    @(negedge clk);
    drive_op(vecs[0]);
    kill = 1'b1;
    #1;
    chk("killC.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    #1;
    chk("killC.res_valid", 32'(res_valid), 32'd0);
    chk("killC.in_ready", 32'(in_ready), 32'd1);

`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches, 32'd15);
    chk("stat_mispred", stat_mispred, 32'd7);
`else
    chk("stat_branches_off", stat_branches, 32'd0);
    chk("stat_mispred_off", stat_mispred, 32'd0);
`endif

    // reset while a redirect is pending drops it
    @(negedge clk);
    drive_op(vecs[8]);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid.redir_valid_before", 32'(redir_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid.redir_valid", 32'(redir_valid), 32'd0);
    chk("rstmid.redir_pc", redir_pc, 32'd0);
    chk("rstmid.stat_mispred", stat_mispred, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid.in_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
